// File: rtl/aes_ctx_controller.sv
// Multi-context AES mode sequencer between the stream FIFOs and aes_top.
// Holds NUM_CTX key/IV slots so sessions can be interleaved, and wraps the
// raw block cipher in ECB, CBC or CTR chaining with one block in flight.
module aes_ctx_controller #(
  parameter int unsigned NUM_CTX     = 4,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned ECB_SUPPORT = 1,
  parameter int unsigned CBC_SUPPORT = 1,
  parameter int unsigned CTR_SUPPORT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_tvalid,
  output logic              cmd_tready,
  input  logic [31:0]       cmd_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic [DATA_W-1:0] in_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tlast,
  output logic              aes_en,
  output logic              aes_key_exp_mode,
  output logic              aes_cipher_mode,
  output logic              aes_decipher_mode,
  output logic              aes128_mode,
  output logic              aes256_mode,
  output logic [255:0]      aes_key,
  output logic [DATA_W-1:0] aes_in_blk,
  input  logic [DATA_W-1:0] aes_out_blk,
  input  logic              aes_done,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int unsigned SLOTS = 1 << CTX_W;

  localparam logic [1:0] ModeEcb = 2'b00;
  localparam logic [1:0] ModeCbc = 2'b01;
  localparam logic [1:0] ModeCtr = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StKeyLo, StKeyHi, StIv, StKeyExp,
    StBlkRd, StBlkWait, StBlkOut, StCtxWb, StDrain
  } state_e;

  state_e state_q, state_d;

  // Latched command fields
  logic [1:0]       mode_q;
  logic             enc_q, k256_q, ldiv_q;
  logic [CTX_W-1:0] ctx_q;
  logic [15:0]      nblk_q, blk_rem_q;
  logic [16:0]      drain_q, drain_d;

  // Working data
  logic [DATA_W-1:0] iv_q, data_q;
  logic [15:0]       ctx_vld_q;

  // Registered outputs
  logic              cmd_tready_q, in_tready_q, out_tvalid_q, out_tlast_q;
  logic [DATA_W-1:0] out_tdata_q, aes_in_blk_q;
  logic              aes_en_q, key_exp_mode_q, cipher_mode_q, decipher_mode_q;
  logic              aes128_q, aes256_q, busy_q, err_q;
  logic [255:0]      aes_key_q;

  // Context storage; contents are not reset, only the valid bits are
  logic [255:0]      key_ram [SLOTS];
  logic [DATA_W-1:0] iv_ram  [SLOTS];

  logic cmd_hs, in_hs, out_hs;
  assign cmd_hs = cmd_tvalid & cmd_tready_q;
  assign in_hs  = in_tvalid & in_tready_q;
  assign out_hs = out_tvalid_q & out_tready;

  // Command decode
  logic [1:0]       c_mode;
  logic             c_enc, c_k256, c_ldk, c_ldiv;
  logic [3:0]       c_ctx;
  logic [CTX_W-1:0] c_ctx_idx;
  logic [15:0]      c_nblk;
  assign c_mode    = cmd_tdata[1:0];
  assign c_enc     = cmd_tdata[2];
  assign c_k256    = cmd_tdata[3];
  assign c_ldk     = cmd_tdata[4];
  assign c_ldiv    = cmd_tdata[5];
  assign c_ctx     = cmd_tdata[11:8];
  assign c_ctx_idx = cmd_tdata[8 +: CTX_W];
  assign c_nblk    = cmd_tdata[31:16];

  logic unused_cmd;
  assign unused_cmd = ^{cmd_tdata[15:12], cmd_tdata[7:6]};

  logic        c_mode_ok, c_err;
  logic [16:0] c_drain;
  logic        key_we, in_rd_d, blk_d;
  logic [255:0]      key_wdata;
  logic [DATA_W-1:0] blk_in_c, out_c, iv_next_c;

  // Command legality and the number of input words an errored command still owns
  always_comb begin
    case (c_mode)
      ModeEcb: c_mode_ok = (ECB_SUPPORT != 0);
      ModeCbc: c_mode_ok = (CBC_SUPPORT != 0);
      ModeCtr: c_mode_ok = (CTR_SUPPORT != 0);
      default: c_mode_ok = 1'b0;
    endcase
    c_err = !c_mode_ok || ({28'd0, c_ctx} >= NUM_CTX) || (!c_ldk && !ctx_vld_q[c_ctx]);
    c_drain = {1'b0, c_nblk}
            + (c_ldk ? (c_k256 ? 17'd2 : 17'd1) : 17'd0)
            + (c_ldiv ? 17'd1 : 17'd0);
  end

  // Chaining datapath: cipher input, output block and next IV per mode
  always_comb begin
    case (mode_q)
      ModeCbc: begin
        blk_in_c  = enc_q ? (in_tdata ^ iv_q) : in_tdata;
        out_c     = enc_q ? aes_out_blk : (aes_out_blk ^ iv_q);
        iv_next_c = enc_q ? aes_out_blk : data_q;
      end
      ModeCtr: begin
        blk_in_c  = iv_q;
        out_c     = aes_out_blk ^ data_q;
        iv_next_c = iv_q + {{(DATA_W-1){1'b0}}, 1'b1};
      end
      default: begin
        blk_in_c  = in_tdata;
        out_c     = aes_out_blk;
        iv_next_c = iv_q;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          if (c_err) begin
            state_d = StDrain;
            drain_d = c_drain;
          end else if (c_ldk) begin
            state_d = StKeyLo;
          end else if (c_ldiv) begin
            state_d = StIv;
          end else begin
            state_d = StKeyExp;
          end
        end
      end
      StKeyLo:   if (in_hs) state_d = k256_q ? StKeyHi : (ldiv_q ? StIv : StKeyExp);
      StKeyHi:   if (in_hs) state_d = ldiv_q ? StIv : StKeyExp;
      StIv:      if (in_hs) state_d = StKeyExp;
      StKeyExp:  if (aes_done) state_d = (nblk_q == 16'd0) ? StCtxWb : StBlkRd;
      StBlkRd:   if (in_hs) state_d = StBlkWait;
      StBlkWait: if (aes_done) state_d = StBlkOut;
      StBlkOut:  if (out_hs) state_d = out_tlast_q ? StCtxWb : StBlkRd;
      StCtxWb:   state_d = StIdle;
      StDrain: begin
        if (drain_q == 17'd0) begin
          state_d = StIdle;
        end else if (in_hs) begin
          drain_d = drain_q - 17'd1;
          if (drain_q == 17'd1) state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase

    in_rd_d = (state_d inside {StKeyLo, StKeyHi, StIv, StBlkRd}) ||
              (state_d == StDrain && drain_d != 17'd0);
    blk_d   = state_d inside {StBlkRd, StBlkWait, StBlkOut};

    key_we    = in_hs && ((state_q == StKeyLo && !k256_q) || state_q == StKeyHi);
    key_wdata = (state_q == StKeyHi) ? {in_tdata, aes_key_q[127:0]} : {128'd0, in_tdata};
  end

  // Slot writes: key when loading completes, IV on writeback
  always_ff @(posedge clk) begin
    if (key_we) key_ram[ctx_q] <= key_wdata;
    if (state_q == StCtxWb) iv_ram[ctx_q] <= iv_q;
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      drain_q         <= '0;
      mode_q          <= '0;
      enc_q           <= 1'b0;
      k256_q          <= 1'b0;
      ldiv_q          <= 1'b0;
      ctx_q           <= '0;
      nblk_q          <= '0;
      blk_rem_q       <= '0;
      iv_q            <= '0;
      data_q          <= '0;
      ctx_vld_q       <= '0;
      cmd_tready_q    <= 1'b0;
      in_tready_q     <= 1'b0;
      out_tvalid_q    <= 1'b0;
      out_tlast_q     <= 1'b0;
      out_tdata_q     <= '0;
      aes_in_blk_q    <= '0;
      aes_en_q        <= 1'b0;
      key_exp_mode_q  <= 1'b0;
      cipher_mode_q   <= 1'b0;
      decipher_mode_q <= 1'b0;
      aes128_q        <= 1'b0;
      aes256_q        <= 1'b0;
      aes_key_q       <= '0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      drain_q         <= drain_d;
      cmd_tready_q    <= (state_d == StIdle);
      in_tready_q     <= in_rd_d;
      busy_q          <= (state_d != StIdle);
      err_q           <= cmd_hs && c_err;
      // Start pulse on entry to key expansion and one cycle after each block read
      aes_en_q        <= (state_d == StKeyExp && state_q != StKeyExp) ||
                         (state_q == StBlkRd && in_hs);
      key_exp_mode_q  <= (state_d == StKeyExp);
      // CTR only ever runs the forward cipher
      cipher_mode_q   <= blk_d && (enc_q || mode_q == ModeCtr);
      decipher_mode_q <= blk_d && !enc_q && mode_q != ModeCtr;

      if (cmd_hs) begin
        mode_q    <= c_mode;
        enc_q     <= c_enc;
        k256_q    <= c_k256;
        ldiv_q    <= c_ldiv;
        ctx_q     <= c_ctx_idx;
        nblk_q    <= c_nblk;
        blk_rem_q <= c_nblk;
        if (!c_err) begin
          aes128_q  <= !c_k256;
          aes256_q  <= c_k256;
          aes_key_q <= key_ram[c_ctx_idx];
          iv_q      <= iv_ram[c_ctx_idx];
        end
      end

      if (in_hs) begin
        case (state_q)
          StKeyLo: aes_key_q <= {128'd0, in_tdata};
          StKeyHi: aes_key_q[255:128] <= in_tdata;
          StIv:    iv_q <= in_tdata;
          StBlkRd: begin
            data_q       <= in_tdata;
            aes_in_blk_q <= blk_in_c;
          end
          default: ;
        endcase
      end

      if (key_we) ctx_vld_q[ctx_q] <= 1'b1;

      if (state_q == StBlkWait && aes_done) begin
        out_tdata_q  <= out_c;
        out_tvalid_q <= 1'b1;
        out_tlast_q  <= (blk_rem_q == 16'd1);
        iv_q         <= iv_next_c;
      end

      if (out_hs) begin
        out_tvalid_q <= 1'b0;
        out_tlast_q  <= 1'b0;
        blk_rem_q    <= blk_rem_q - 16'd1;
      end
    end
  end

  assign cmd_tready        = cmd_tready_q;
  assign in_tready         = in_tready_q;
  assign out_tvalid        = out_tvalid_q;
  assign out_tdata         = out_tdata_q;
  assign out_tlast         = out_tlast_q;
  assign aes_en            = aes_en_q;
  assign aes_key_exp_mode  = key_exp_mode_q;
  assign aes_cipher_mode   = cipher_mode_q;
  assign aes_decipher_mode = decipher_mode_q;
  assign aes128_mode       = aes128_q;
  assign aes256_mode       = aes256_q;
  assign aes_key           = aes_key_q;
  assign aes_in_blk        = aes_in_blk_q;
  assign busy              = busy_q;
  assign err               = err_q;

endmodule

// File: tb/tb_aes_ctx_controller.sv
// Directed bench for aes_ctx_controller with a small aes_top stand-in.
// The stand-in returns published AES results for the known key/block pairs
// and a simple keyed permutation otherwise.
module tb_aes_ctx_controller;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         cmd_tvalid = 1'b0;
  logic         cmd_tready;
  logic [31:0]  cmd_tdata = '0;
  logic         in_tvalid = 1'b0;
  logic         in_tready;
  logic [127:0] in_tdata = '0;
  logic         out_tvalid;
  logic         out_tready = 1'b0;
  logic [127:0] out_tdata;
  logic         out_tlast;
  logic         aes_en, aes_key_exp_mode, aes_cipher_mode, aes_decipher_mode;
  logic         aes128_mode, aes256_mode;
  logic [255:0] aes_key;
  logic [127:0] aes_in_blk;
  logic [127:0] aes_out_blk = '0;
  logic         aes_done = 1'b0;
  logic         busy, err;

  aes_ctx_controller #(.NUM_CTX(4)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .cmd_tvalid        (cmd_tvalid),
    .cmd_tready        (cmd_tready),
    .cmd_tdata         (cmd_tdata),
    .in_tvalid         (in_tvalid),
    .in_tready         (in_tready),
    .in_tdata          (in_tdata),
    .out_tvalid        (out_tvalid),
    .out_tready        (out_tready),
    .out_tdata         (out_tdata),
    .out_tlast         (out_tlast),
    .aes_en            (aes_en),
    .aes_key_exp_mode  (aes_key_exp_mode),
    .aes_cipher_mode   (aes_cipher_mode),
    .aes_decipher_mode (aes_decipher_mode),
    .aes128_mode       (aes128_mode),
    .aes256_mode       (aes256_mode),
    .aes_key           (aes_key),
    .aes_in_blk        (aes_in_blk),
    .aes_out_blk       (aes_out_blk),
    .aes_done          (aes_done),
    .busy              (busy),
    .err               (err)
  );

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int ov_cnt = 0;
  int kexp_cnt = 0;
  int blk_cnt = 0;
  int st_cnt = 0;
  logic [127:0] st_in = '0;
  logic [255:0] st_key = '0;
  logic [127:0] last_in = '0;
  logic         last_cipher = 1'b0;
  logic         last_decipher = 1'b0;

  localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_NIST = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV0    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1     = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2     = 128'h5086cb9b507219ee95db113a917678b2;

  // Stand-in cipher: known-answer pairs, else half-swap XOR key
  function automatic logic [127:0] aes_model(input logic [127:0] blk, input logic [255:0] k);
    if (k[127:0] == K_FIPS && blk == P_FIPS) return C_FIPS;
    if (k[127:0] == K_NIST && blk == 128'h6bc0bce12a459991e134741a7f9e1925) return C1;
    if (k[127:0] == K_NIST && blk == 128'hd86421fb9f1a1eda505ee1375746972c) return C2;
    return {blk[63:0], blk[127:64]} ^ k[127:0] ^ k[255:128];
  endfunction

  // aes_top stand-in: done two cycles after each start pulse
  always @(negedge clk) begin
    if (!resetn) begin
      st_cnt   = 0;
      aes_done = 1'b0;
    end else begin
      aes_done = 1'b0;
      if (st_cnt > 0) begin
        st_cnt--;
        if (st_cnt == 0) begin
          aes_done    = 1'b1;
          aes_out_blk = aes_model(st_in, st_key);
        end
      end
      if (aes_en) begin
        st_in         = aes_in_blk;
        st_key        = aes_key;
        st_cnt        = 2;
        last_in       = aes_in_blk;
        last_cipher   = aes_cipher_mode;
        last_decipher = aes_decipher_mode;
        if (aes_key_exp_mode) kexp_cnt++;
        else blk_cnt++;
      end
    end
  end

  // Event counters for err pulses and cycles with out_tvalid high
  always @(negedge clk) begin
    if (err) err_cnt++;
    if (out_tvalid) ov_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return cmd_tready | in_tready | out_tvalid | (|out_tdata) | out_tlast | aes_en |
           aes_key_exp_mode | aes_cipher_mode | aes_decipher_mode | aes128_mode |
           aes256_mode | (|aes_key) | (|aes_in_blk) | busy | err;
  endfunction

  task automatic send_cmd(input logic [31:0] c);
    int n = 0;
    @(negedge clk);
    cmd_tdata  = c;
    cmd_tvalid = 1'b1;
    while (cmd_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 128'(n < 200), 128'd1);
    @(negedge clk);
    cmd_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [127:0] w);
    int n = 0;
    @(negedge clk);
    in_tdata  = w;
    in_tvalid = 1'b1;
    while (in_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_accept", 128'(n < 200), 128'd1);
    @(negedge clk);
    in_tvalid = 1'b0;
  endtask

  task automatic get_out(input string tag, input logic [127:0] exp, input logic exp_last);
    int n = 0;
    @(negedge clk);
    out_tready = 1'b1;
    while (out_tvalid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 128'(n < 200), 128'd1);
    check({tag, "_data"}, out_tdata, exp);
    check({tag, "_last"}, 128'(out_tlast), 128'(exp_last));
    @(negedge clk);
    out_tready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cmd_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 128'(n < 200), 128'd1);
  endtask

  initial begin
    int e0, o0;
    logic stall_bad;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", 128'(any_out()), 128'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_cmd_tready", 128'(cmd_tready), 128'd1);
    check("idle_busy", 128'(busy), 128'd0);

    // ECB encrypt, load key into ctx0, one block
    send_cmd(32'h0001_0014);
    send_word(K_FIPS);
    send_word(P_FIPS);
    get_out("ecb", C_FIPS, 1'b1);
    check("ecb_keyexp_runs", 128'(kexp_cnt), 128'd1);
    check("ecb_block_runs", 128'(blk_cnt), 128'd1);
    wait_idle("ecb");

    // CBC encrypt, load key and IV into ctx2
    send_cmd(32'h0001_0235);
    send_word(K_NIST);
    send_word(IV0);
    send_word(P1);
    get_out("cbc1", C1, 1'b1);
    wait_idle("cbc1");

    // CBC reuse of ctx2 continues the chain
    send_cmd(32'h0001_0205);
    send_word(P2);
    get_out("cbc2", C2, 1'b1);
    check("cbc2_keyexp_rerun", 128'(kexp_cnt), 128'd3);
    wait_idle("cbc2");

    // Reuse of never-loaded ctx1 with 3 blocks: error and drain
    e0 = err_cnt;
    o0 = ov_cnt;
    send_cmd(32'h0003_0104);
    send_word(128'h1);
    send_word(128'h2);
    send_word(128'h3);
    wait_idle("drain_inv");
    check("drain_inv_err", 128'(err_cnt - e0), 128'd1);
    check("drain_inv_no_out", 128'(ov_cnt - o0), 128'd0);
    check("drain_inv_in_tready", 128'(in_tready), 128'd0);

    // Next command after an error runs normally
    send_cmd(32'h0001_0004);
    send_word(P_FIPS);
    get_out("ecb_reuse", C_FIPS, 1'b1);
    wait_idle("ecb_reuse");

    // Mode 11 with key and IV load: error, two words drained
    e0 = err_cnt;
    send_cmd(32'h0000_0033);
    send_word(128'h4);
    send_word(128'h5);
    wait_idle("mode11");
    check("mode11_err", 128'(err_cnt - e0), 128'd1);

    // ctx 5 beyond NUM_CTX: error, key plus one block drained
    e0 = err_cnt;
    send_cmd(32'h0001_0514);
    send_word(128'h6);
    send_word(128'h7);
    wait_idle("ctx_range");
    check("ctx_range_err", 128'(err_cnt - e0), 128'd1);

    // nblk=0 initialises ctx1 only, then reuse it
    o0 = ov_cnt;
    e0 = err_cnt;
    send_cmd(32'h0000_0135);
    send_word(K_NIST);
    send_word(IV0);
    wait_idle("init_ctx1");
    check("init_ctx1_no_out", 128'(ov_cnt - o0), 128'd0);
    send_cmd(32'h0001_0105);
    send_word(P1);
    get_out("ctx1_reuse", C1, 1'b1);
    check("ctx1_reuse_no_err", 128'(err_cnt - e0), 128'd0);
    wait_idle("ctx1_reuse");

    // CTR (dec bit set) with all-ones counter, 2 blocks: second counter wraps to 0
    send_cmd(32'h0002_0332);
    send_word(128'h11111111111111111111111111111111);
    send_word({128{1'b1}});
    send_word(128'h0);
    get_out("ctr0", 128'heeeeeeeeeeeeeeeeeeeeeeeeeeeeeeee, 1'b0);
    send_word(128'hff);
    get_out("ctr1", 128'h111111111111111111111111111111ee, 1'b1);
    check("ctr_wrap_counter", last_in, 128'h0);
    check("ctr_cipher_mode", 128'({last_cipher, last_decipher}), 128'b10);
    wait_idle("ctr");

    // Stall output for 20 cycles mid-packet
    send_cmd(32'h0002_0004);
    send_word(P_FIPS);
    begin
      int n = 0;
      while (out_tvalid !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("stall_valid", 128'(n < 200), 128'd1);
    end
    stall_bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_tvalid !== 1'b1 || out_tdata !== C_FIPS || in_tready !== 1'b0) stall_bad = 1'b1;
    end
    check("stall_hold_stable", 128'(stall_bad), 128'd0);
    get_out("stall_blk0", C_FIPS, 1'b0);

    // Second block in flight, then reset inside BLK_WAIT
    send_word(P_FIPS);
    check("blk_wait_aes_en", 128'(aes_en), 128'd1);
    resetn = 1'b0;
    #1;
    check("midop_reset_outputs_zero", 128'(any_out()), 128'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_tready", 128'(cmd_tready), 128'd1);
    check("post_reset_busy", 128'(busy), 128'd0);

    // Contexts invalid after reset: reuse of ctx0 errors
    e0 = err_cnt;
    o0 = ov_cnt;
    send_cmd(32'h0001_0004);
    send_word(P_FIPS);
    wait_idle("post_reset");
    check("post_reset_ctx_invalid", 128'(err_cnt - e0), 128'd1);
    check("post_reset_no_out", 128'(ov_cnt - o0), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
